// File: rtl/dmux8way16_stream.sv
// dmux8way16_stream: 1-to-8 word distributor with per-channel single-word
// holding registers and valid/ready handshakes on every port. Destination is
// either a round-robin pointer (mode=0) or an explicit channel address (mode=1).
module dmux8way16_stream #(
  parameter int WIDTH   = 16,
  parameter int CH_BITS = 3,
  localparam int NCH    = 1 << CH_BITS
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [WIDTH-1:0]       in,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   mode,
  input  logic [CH_BITS-1:0]     sel,
  output logic [NCH*WIDTH-1:0]   out,
  output logic [NCH-1:0]         out_valid,
  input  logic [NCH-1:0]         out_ready,
  output logic [CH_BITS-1:0]     ptr,
  output logic                   busy
);

  logic [NCH-1:0][WIDTH-1:0] hold;
  logic [NCH-1:0]            full;
  logic [CH_BITS-1:0]        ptr_q;
  logic [CH_BITS-1:0]        dest;
  logic                      accept;

  // Destination select and input handshake; a full channel may still accept
  // when its consumer drains it on the same edge.
  always_comb begin
    dest     = mode ? sel : ptr_q;
    in_ready = ~full[dest] | out_ready[dest];
    accept   = in_valid & in_ready;
  end

  // Channel load/drain and round-robin pointer advance.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      hold  <= '0;
      full  <= '0;
      ptr_q <= '0;
    end else begin
      for (int unsigned k = 0; k < NCH; k++) begin
        if (accept && (dest == CH_BITS'(k))) begin
          hold[k] <= in;
          full[k] <= 1'b1;
        end else if (full[k] && out_ready[k]) begin
          full[k] <= 1'b0;
        end
      end
      if (accept && !mode)
        ptr_q <= ptr_q + 1'b1;
    end
  end

  // Output mapping straight from state registers.
  always_comb begin
    out       = hold;
    out_valid = full;
    ptr       = ptr_q;
    busy      = |full;
  end

endmodule

// File: tb/tb_dmux8way16_stream.sv
// Directed-vector bench for dmux8way16_stream.
module tb_dmux8way16_stream;

  logic         clock = 1'b0;
  logic         reset_n;
  logic [15:0]  din;
  logic         in_valid;
  logic         in_ready;
  logic         mode;
  logic [2:0]   sel;
  logic [127:0] dout;
  logic [7:0]   out_valid;
  logic [7:0]   out_ready;
  logic [2:0]   ptr;
  logic         busy;

  int nvec = 0;
  int nerr = 0;

  dmux8way16_stream #(.WIDTH(16), .CH_BITS(3)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in        (din),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out       (dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ptr       (ptr),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [15:0] chan(input logic [127:0] v, input int k);
    return v[k*16 +: 16];
  endfunction

  initial begin
    reset_n = 1'b0; din = 16'hDEAD; in_valid = 1'b1;
    mode = 1'b0; sel = 3'd7; out_ready = 8'h00;

    // Reset held two edges with a word offered
    tick(); tick();
    check("rst_valid", 128'(out_valid), 128'h00);
    check("rst_ptr",   128'(ptr), 128'h0);
    check("rst_busy",  128'(busy), 128'h0);
    check("rst_out",   dout, 128'h0);
    reset_n = 1'b1; in_valid = 1'b0; #1;
    check("rst_ready", 128'(in_ready), 128'h1);

    // Round-robin fill of all eight channels
    for (int i = 0; i < 8; i++) begin
      din = 16'h1000 + 16'(i); in_valid = 1'b1; #1;
      check("rr_ready", 128'(in_ready), 128'h1);
      tick();
    end
    din = 16'h1008; #1;
    check("rr_valid", 128'(out_valid), 128'hFF);
    check("rr_ptr",   128'(ptr), 128'h0);
    check("rr_stall", 128'(in_ready), 128'h0);
    for (int k = 0; k < 8; k++)
      check("rr_data", 128'(chan(dout, k)), 128'(16'h1000 + 16'(k)));
    tick();
    check("rr_hold_ptr", 128'(ptr), 128'h0);
    check("rr_hold_ch0", 128'(chan(dout, 0)), 128'h1000);
    check("rr_hold_val", 128'(out_valid), 128'hFF);

    // Same-edge drain and load on channel 0
    din = 16'hBEEF; out_ready = 8'h01; #1;
    check("pt_ready", 128'(in_ready), 128'h1);
    tick();
    check("pt_ch0",   128'(chan(dout, 0)), 128'hBEEF);
    check("pt_valid", 128'(out_valid), 128'hFF);
    check("pt_ptr",   128'(ptr), 128'h1);
    check("pt_ch1",   128'(chan(dout, 1)), 128'h1001);

    // Drain channel 5, then address it directly
    in_valid = 1'b0; out_ready = 8'h20; tick();
    check("ad_drain", 128'(out_valid), 128'hDF);
    out_ready = 8'h00; mode = 1'b1; sel = 3'd5; din = 16'h00A5; in_valid = 1'b1; #1;
    check("ad_ready", 128'(in_ready), 128'h1);
    tick();
    check("ad_ch5",   128'(chan(dout, 5)), 128'h00A5);
    check("ad_ch4",   128'(chan(dout, 4)), 128'h1004);
    check("ad_valid", 128'(out_valid), 128'hFF);
    check("ad_ptr",   128'(ptr), 128'h1);
    din = 16'h55AA; #1;
    check("ad_stall", 128'(in_ready), 128'h0);
    tick();
    check("ad_keep",  128'(chan(dout, 5)), 128'h00A5);
    check("ad_ptr2",  128'(ptr), 128'h1);

    // Leave only channels 2,3,6 full, then drain them while loading channel 1
    in_valid = 1'b0; out_ready = 8'b1011_0011; tick();
    check("sm_pre", 128'(out_valid), 128'h4C);
    out_ready = 8'b0100_1100; sel = 3'd1; din = 16'h0011; in_valid = 1'b1; #1;
    check("sm_ready", 128'(in_ready), 128'h1);
    tick();
    check("sm_valid", 128'(out_valid), 128'h02);
    check("sm_ch1",   128'(chan(dout, 1)), 128'h0011);
    check("sm_busy",  128'(busy), 128'h1);

    // Drain out, queue four words round-robin from ptr=1, reset mid-stream
    in_valid = 1'b0; out_ready = 8'h02; tick();
    check("ms_idle", 128'(busy), 128'h0);
    out_ready = 8'h00; mode = 1'b0; sel = 3'd6;
    for (int i = 0; i < 4; i++) begin
      din = 16'h2000 + 16'(i); in_valid = 1'b1; tick();
    end
    check("ms_valid", 128'(out_valid), 128'h1E);
    check("ms_ptr",   128'(ptr), 128'h5);
    check("ms_ch4",   128'(chan(dout, 4)), 128'h2003);
    din = 16'h2004; reset_n = 1'b0; tick();
    check("ms_rst_valid", 128'(out_valid), 128'h00);
    check("ms_rst_ptr",   128'(ptr), 128'h0);
    check("ms_rst_out",   dout, 128'h0);
    reset_n = 1'b1; din = 16'h3000; tick();
    check("ms_next_valid", 128'(out_valid), 128'h01);
    check("ms_next_ch0",   128'(chan(dout, 0)), 128'h3000);
    check("ms_next_ptr",   128'(ptr), 128'h1);
    in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
